// File: rtl/count_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : count_fsm
//  Description : Free-running 3-bit sequence counter. After each reset
//                release it ramps once from 0 up to MAX_VAL. From then on it
//                loops WRAP_VAL..MAX_VAL until the next reset.
//
//  Parameters  : MAX_VAL  - terminal count; the next edge reloads WRAP_VAL
//                WRAP_VAL - reload value, lowest value of the steady loop
//                           (WRAP_VAL < MAX_VAL <= 7)
//  Ports       : clk      - sole clock, rising edge
//                rst      - synchronous, active-low reset
//                count    - current counter value, straight from a register
//
//  Revision    : 1.0 - initial release
// ============================================================================
module count_fsm #(
    parameter int MAX_VAL  = 7,
    parameter int WRAP_VAL = 3
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] count
);

    localparam logic [2:0] c_max_val  = 3'(MAX_VAL);
    localparam logic [2:0] c_wrap_val = 3'(WRAP_VAL);

    // The RESET / RAMP / LOOP phases are fully encoded by the count value
    // itself, so the count register is the only state in the block.
    logic [2:0] w_count_next;

    // Next-state decode. The reload at MAX_VAL happens before the +1 can
    // carry out of 3 bits, so the increment never wraps on its own.
    always_comb begin
        w_count_next = count + 3'd1;
        if (count == c_max_val) begin
            w_count_next = c_wrap_val;
        end
    end

    // State register. Reset is checked first so it overrides the terminal
    // reload when both land on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= 3'd0;
        end else begin
            count <= w_count_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_count_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_fsm
//  Description : Scoreboard bench for count_fsm. The stimulus process drives
//                rst ahead of each rising edge and queues the hand-computed
//                count expected after that edge; the monitor pops and checks
//                shortly after every rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_fsm;

    logic       clk;
    logic       rst;
    logic [2:0] count;

    int vec_count;
    int miss_count;

    logic [2:0] exp_q[$];
    string      tag_q[$];

    count_fsm #(
        .MAX_VAL (7),
        .WRAP_VAL(3)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare whenever an expectation is pending for this edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [2:0] e;
                string      t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                vec_count++;
                if (count !== e) begin
                    miss_count++;
                    $display("FAIL %s: count=%0d expected=%0d at %0t", t, count, e, $time);
                end
            end
        end
    end

    // One clock of stimulus: set rst mid-cycle and queue the expected count
    // after the following rising edge. With glitch set, rst dips low briefly
    // but is back high well before the edge.
    task automatic step(input logic r, input logic [2:0] e, input string t,
                        input bit glitch);
        @(negedge clk);
        rst = r;
        exp_q.push_back(e);
        tag_q.push_back(t);
        if (glitch) begin
            #1 rst = 1'b0;
            #1 rst = 1'b1;
        end
    endtask

    // Expected ramp-then-loop value after the n-th edge since release (n>=1).
    function automatic logic [2:0] seq_val(input int n);
        if (n <= 7) return 3'(n);
        return 3'(3 + ((n - 8) % 5));
    endfunction

    initial begin
        logic [2:0] run10 [10];
        logic [2:0] glit8 [8];
        int         guard;

        run10 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3, 3'd4, 3'd5};
        glit8 = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3, 3'd4};

        vec_count  = 0;
        miss_count = 0;
        rst        = 1'b0;

        // Reset held for four edges.
        for (int i = 0; i < 4; i++) step(1'b0, 3'd0, "reset_hold", 1'b0);

        // First ramp and into the loop, ending at 5.
        for (int i = 0; i < 10; i++) step(1'b1, run10[i], "first_run", 1'b0);

        // Reset while count is 5, held two edges.
        step(1'b0, 3'd0, "reset_at_5", 1'b0);
        step(1'b0, 3'd0, "reset_hold2", 1'b0);

        // Long run: full ramp restarts, then steady loop; ends at 7.
        for (int n = 1; n <= 32; n++) step(1'b1, seq_val(n), "long_run", 1'b0);

        // Single-edge reset coincident with the 7 -> 3 reload.
        step(1'b0, 3'd0, "reset_beats_wrap", 1'b0);
        step(1'b1, 3'd1, "release_after_pulse", 1'b0);

        // Between-edge glitches on rst must not disturb the sequence.
        for (int i = 0; i < 8; i++) step(1'b1, glit8[i], "glitch_immune", 1'b1);

        // Drain the scoreboard with a bounded wait.
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() > 0) begin
            miss_count++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
`default_nettype wire
